// File: rtl/parallel_pe.sv
// Multi-lane signed MAC: lane products -> pipelined adder tree -> accumulator -> shift/saturate.
// Latency: vld_o rises in the cycle after edge TL+3, counting the edge that samples the last beat as edge 0.
// No backpressure: a beat is accepted every cycle and back-to-back vectors stream through.
module parallel_pe #(
    parameter int LANES = 32,
    parameter int DW    = 16,
    parameter int ACC_W = 48,
    parameter int RES_W = 32,
    parameter int FRAC  = 0,
    parameter int SAT   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LANES*DW-1:0]   neuron,
    input  logic [LANES*DW-1:0]   weight,
    input  logic [1:0]            ctl,
    input  logic                  vld_i,
    output logic [RES_W-1:0]      result,
    output logic                  vld_o,
    output logic                  ovf_o
);
    localparam int TL    = $clog2(LANES);
    localparam int PW    = 2 * DW;
    localparam int SW    = PW + TL;
    localparam int NODES = 2 * LANES - 1;

    localparam logic [RES_W-1:0] RMAX = {1'b0, {(RES_W-1){1'b1}}};
    localparam logic [RES_W-1:0] RMIN = {1'b1, {(RES_W-1){1'b0}}};

    // Heap-ordered tree: node 0 is the root, leaves sit at LANES-1 .. 2*LANES-2.
    // Every node is a register, so each level of the tree is one pipeline stage.
    // All nodes share the final tree width; sign extension keeps the sums exact.
    logic signed [SW-1:0]    node [NODES];
    logic                    pv   [TL+1];
    logic [1:0]              pc   [TL+1];
    logic signed [ACC_W-1:0] acc;
    logic                    acc_vld;
    logic signed [ACC_W-1:0] shf;
    logic                    shf_vld;
    logic [ACC_W-RES_W:0]    top;
    logic                    fits;
    logic [RES_W-1:0]        o_res;
    logic                    o_ovf;

    function automatic logic signed [PW-1:0] mul(input logic signed [DW-1:0] a,
                                                 input logic signed [DW-1:0] b);
        return PW'(a) * PW'(b);
    endfunction

    // Leaves take the lane products; internal nodes add their two children.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < NODES; n++) node[n] <= '0;
        end else begin
            for (int i = 0; i < LANES; i++)
                node[LANES-1+i] <= SW'(mul(neuron[(LANES-1-i)*DW +: DW],
                                           weight[(LANES-1-i)*DW +: DW]));
            for (int j = 0; j < LANES-1; j++)
                node[j] <= node[2*j+1] + node[2*j+2];
        end
    end

    // Beat valid and first/last markers travel alongside the products and tree levels.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k <= TL; k++) begin
                pv[k] <= 1'b0;
                pc[k] <= 2'b00;
            end
        end else begin
            pv[0] <= vld_i;
            pc[0] <= ctl;
            for (int k = 1; k <= TL; k++) begin
                pv[k] <= pv[k-1];
                pc[k] <= pc[k-1];
            end
        end
    end

    // Accumulate valid beats; a first marker restarts the sum, dropping any partial vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            acc_vld <= 1'b0;
        end else begin
            acc_vld <= pv[TL] & pc[TL][1];
            if (pv[TL]) begin
                if (pc[TL][0]) acc <= ACC_W'(node[0]);
                else           acc <= acc + ACC_W'(node[0]);
            end
        end
    end

    // Snapshot the finished vector, scaled by the fixed-point shift, before acc moves on.
    always_ff @(posedge clk) begin
        if (rst) begin
            shf     <= '0;
            shf_vld <= 1'b0;
        end else begin
            shf_vld <= acc_vld;
            shf     <= acc >>> FRAC;
        end
    end

    // Range check: the value fits when all bits from RES_W-1 upward agree with the sign.
    always_comb begin
        top   = shf[ACC_W-1:RES_W-1];
        fits  = (&top) | ~(|top);
        o_ovf = ~fits;
        o_res = shf[RES_W-1:0];
        if (SAT != 0 && !fits) o_res = shf[ACC_W-1] ? RMIN : RMAX;
    end

    // Output register: one-cycle valid pulse, result and overflow held until the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
            ovf_o  <= 1'b0;
            vld_o  <= 1'b0;
        end else begin
            vld_o <= shf_vld;
            if (shf_vld) begin
                result <= o_res;
                ovf_o  <= o_ovf;
            end
        end
    end
endmodule

// File: tb/tb_parallel_pe.sv
// Bench for parallel_pe: a default instance (FRAC=0, SAT=1) and a FRAC=8, SAT=0 instance share stimulus.
// Expected results are queued when the last beat is driven and checked when vld_o appears.
// Both instances have identical latency, so one queue entry carries the expectations for both.
module tb_parallel_pe;
    localparam int LANES = 32;
    localparam int DW    = 16;
    localparam int LAT   = 9;  // from drive-time cycle count to the negedge where vld_o is seen

    logic                clk = 1'b0;
    logic                rst;
    logic [LANES*DW-1:0] neuron;
    logic [LANES*DW-1:0] weight;
    logic [1:0]          ctl;
    logic                vld_i;
    logic [31:0]         ra, rb;
    logic                va, vb, oa, ob;

    parallel_pe u_a (
        .clk(clk), .rst(rst), .neuron(neuron), .weight(weight), .ctl(ctl), .vld_i(vld_i),
        .result(ra), .vld_o(va), .ovf_o(oa)
    );

    parallel_pe #(.FRAC(8), .SAT(0)) u_b (
        .clk(clk), .rst(rst), .neuron(neuron), .weight(weight), .ctl(ctl), .vld_i(vld_i),
        .result(rb), .vld_o(vb), .ovf_o(ob)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [31:0] ra;
        logic        oa;
        logic [31:0] rb;
        logic        ob;
    } exp_t;

    typedef struct {
        logic [15:0] n;
        logic [15:0] w;
        bit          half;   // odd lanes get weight 0
        int          nbeats;
        int          gap;    // idle cycles between beat 2 and beat 3
        int          idle;   // idle cycles after the vector
        logic [31:0] ra;
        logic        oa;
        logic [31:0] rb;
        logic        ob;
    } vec_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
        total++;
        if (act !== ex) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, ex, cyc);
        end
    endtask

    task automatic drive_beat(input logic [15:0] n, input logic [15:0] w, input bit half,
                              input logic [1:0] c);
        @(negedge clk);
        for (int i = 0; i < LANES; i++) begin
            neuron[(LANES-1-i)*DW +: DW] = n;
            weight[(LANES-1-i)*DW +: DW] = (half && (i % 2 == 1)) ? 16'h0000 : w;
        end
        ctl   = c;
        vld_i = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            vld_i = 1'b0;
            ctl   = 2'b00;
        end
    endtask

    task automatic expect_res(input logic [31:0] a, input logic o1,
                              input logic [31:0] b, input logic o2);
        exp_t e;
        e.cyc = cyc + LAT;
        e.ra  = a;
        e.oa  = o1;
        e.rb  = b;
        e.ob  = o2;
        q.push_back(e);
    endtask

    task automatic run_vec(input vec_t v);
        for (int b = 0; b < v.nbeats; b++) begin
            drive_beat(v.n, v.w, v.half, {b == v.nbeats-1, b == 0});
            if (b == v.nbeats-1) expect_res(v.ra, v.oa, v.rb, v.ob);
            if (b == 1) idle(v.gap);
        end
        idle(v.idle);
    endtask

    // Scoreboard: every vld_o pulse must match the oldest expectation at its exact cycle.
    always @(negedge clk) begin
        exp_t e;
        if (va || vb) begin
            if (q.size() == 0) begin
                chk("unexpected_vld", {30'b0, vb, va}, 32'd0);
            end else begin
                e = q.pop_front();
                chk("vld_cycle", cyc, e.cyc);
                chk("vld_pair", {31'b0, va & vb}, 32'd1);
                chk("res_a", ra, e.ra);
                chk("ovf_a", {31'b0, oa}, {31'b0, e.oa});
                chk("res_b", rb, e.rb);
                chk("ovf_b", {31'b0, ob}, {31'b0, e.ob});
            end
        end else if (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            chk("missing_vld_at", cyc, e.cyc);
        end
    end

    vec_t vecs[$];

    initial begin
        vec_t v;
        //        n        w        half nb gap idle ra            oa    rb            ob
        vecs.push_back('{16'h0001, 16'h0001, 0, 1, 0, 0, 32'h00000020, 1'b0, 32'h00000000, 1'b0});
        vecs.push_back('{16'h0002, 16'h0002, 0, 1, 0, 0, 32'h00000080, 1'b0, 32'h00000000, 1'b0});
        vecs.push_back('{16'h0003, 16'h0003, 0, 1, 0, 4, 32'h00000120, 1'b0, 32'h00000001, 1'b0});
        vecs.push_back('{16'h0002, 16'hFFFF, 0, 4, 3, 2, 32'hFFFFFF00, 1'b0, 32'hFFFFFFFF, 1'b0});
        vecs.push_back('{16'h7FFF, 16'h7FFF, 0, 1, 0, 1, 32'h7FFFFFFF, 1'b1, 32'h07FFE000, 1'b0});
        vecs.push_back('{16'h8000, 16'h7FFF, 0, 1, 0, 1, 32'h80000000, 1'b1, 32'hF8001000, 1'b0});
        vecs.push_back('{16'h0100, 16'h0100, 0, 1, 0, 1, 32'h00200000, 1'b0, 32'h00002000, 1'b0});
        vecs.push_back('{16'h8000, 16'h8000, 0, 16, 0, 1, 32'h7FFFFFFF, 1'b1, 32'h80000000, 1'b1});
        vecs.push_back('{16'h0003, 16'h0005, 1, 1, 0, 1, 32'h000000F0, 1'b0, 32'h00000000, 1'b0});
        vecs.push_back('{16'hFFFF, 16'h0003, 0, 1, 0, 1, 32'hFFFFFFA0, 1'b0, 32'hFFFFFFFF, 1'b0});

        rst    = 1'b1;
        vld_i  = 1'b0;
        ctl    = 2'b00;
        neuron = '0;
        weight = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_res_a", ra, 32'd0);
        chk("reset_res_b", rb, 32'd0);
        chk("reset_flags", {28'b0, va, oa, vb, ob}, 32'd0);

        foreach (vecs[k]) begin
            v = vecs[k];
            run_vec(v);
        end
        idle(12);

        // A first marker mid-vector discards the partial sum (32+32) and restarts.
        drive_beat(16'h0001, 16'h0001, 0, 2'b01);
        drive_beat(16'h0001, 16'h0001, 0, 2'b00);
        drive_beat(16'h0002, 16'h0002, 0, 2'b01);
        drive_beat(16'h0001, 16'h0001, 0, 2'b10);
        expect_res(32'h000000A0, 1'b0, 32'h00000000, 1'b0);
        idle(14);
        chk("hold_res_a", ra, 32'h000000A0);

        // Reset 3 cycles after a last beat kills it; a beat presented with rst is dropped.
        drive_beat(16'h0001, 16'h0001, 0, 2'b11);
        idle(2);
        drive_beat(16'h0005, 16'h0005, 0, 2'b11);
        rst = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        vld_i = 1'b0;
        ctl   = 2'b00;
        idle(14);
        chk("post_rst_res_a", ra, 32'd0);
        chk("post_rst_res_b", rb, 32'd0);
        chk("post_rst_flags", {28'b0, va, oa, vb, ob}, 32'd0);

        // Last-only beats after reset accumulate onto a zero accumulator.
        drive_beat(16'h0001, 16'h0001, 0, 2'b10);
        expect_res(32'h00000020, 1'b0, 32'h00000000, 1'b0);
        drive_beat(16'h0001, 16'h0001, 0, 2'b10);
        expect_res(32'h00000040, 1'b0, 32'h00000000, 1'b0);
        idle(15);

        chk("queue_drained", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/parallel_pe.md
# parallel_pe

Parametrised multi-lane multiply-accumulate processing element, the successor to `serial_pe`. Each beat consumes LANES signed neuron/weight pairs, reduces their products through a pipelined adder tree and accumulates across beats between a first and a last marker. At the end of a vector it emits one fixed-point, optionally saturated result. It sits between the neuron/weight line buffers and the result writeback in the accelerator datapath.

## Interface
- LANES, 32: lanes per beat; a power of two, 1..64.
- DW, 16: width of each signed neuron and weight element.
- ACC_W, 48: internal accumulator width; must be at least 2*DW+clog2(LANES).
- RES_W, 32: width of the signed result.
- FRAC, 0: arithmetic right shift applied to the accumulator before output (0..ACC_W-RES_W).
- SAT, 1: 1 = saturate to the RES_W signed range; 0 = truncate to the low RES_W bits.
- clk  in  1  the single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- neuron  in  LANES*DW  packed neuron elements; lane 0 occupies the most significant DW bits.
- weight  in  LANES*DW  packed weight elements; same packing as neuron.
- ctl  in  2  ctl[0] = first beat of a vector; ctl[1] = last beat of a vector. Both may be set on the same beat.
- vld_i  in  1  the beat on neuron/weight/ctl is valid.
- result  out  RES_W  the vector result, shifted and saturated or truncated.
- vld_o  out  1  one-cycle pulse; result is new in this cycle.
- ovf_o  out  1  the result in this cycle was clipped (SAT=1) or wrapped (SAT=0); valid when vld_o=1.

## Operation
- Stage P: each lane computes prod[i] = $signed(neuron_i) * $signed(weight_i), a 2*DW-bit result, into a register. ctl and vld_i are registered alongside.
- Stages T1..TL, where TL = clog2(LANES) (TL = 0 when LANES = 1): a registered binary adder tree. Each level sign-extends its operands by 1 bit, so the tree sum is 2*DW+TL bits. No overflow is possible inside the tree.
- Stage A: acts only on a valid beat; invalid beats (bubbles) leave acc unchanged.
  - first=1: acc <= sext(sum). Any unfinished partial vector is discarded without a result.
  - first=0: acc <= acc + sext(sum), modulo 2^ACC_W.
  - last=1: the new acc value is passed to stage O with a valid flag.
- Stage O: s = acc >>> FRAC (arithmetic shift).
  - SAT=1: s above 2^(RES_W-1)-1 is clipped to that maximum; s below -2^(RES_W-1) is clipped to that minimum. ovf_o is set when clipping occurs.
  - SAT=0: result = s[RES_W-1:0]. ovf_o is set when s does not fit in RES_W signed bits.
  - Stage O registers result and ovf_o and asserts vld_o for one cycle.
- A beat with last=1 but no prior first since reset accumulates onto the current acc (0 after reset).
- There is no backpressure: a new beat is accepted on every cycle, and back-to-back vectors are fully supported.
- result and ovf_o hold their values between vld_o pulses.

## Timing
- Latency: the rising edge that samples the last beat (vld_i=1, ctl[1]=1) is edge 0. vld_o is high in the cycle following edge TL+3. For LANES=32 that is edge 8.
- Throughput: one beat per cycle. A one-beat vector may follow a one-beat vector every cycle, giving vld_o on consecutive cycles.
- Bubbles (vld_i=0) inside a vector add no accumulation. Latency is measured from the last beat only.
- Reset values: result=0, vld_o=0, ovf_o=0, acc=0, and all pipeline valid/ctl registers=0.
- rst asserted in any cycle invalidates all in-flight beats. No vld_o is produced for a vector interrupted by reset.
- rst has priority over vld_i in the same cycle; the beat presented in that cycle is dropped.

## Test plan
- LANES=32, all neuron and weight elements = 0x0001, a single beat with ctl=2'b11 -> 8 cycles later: vld_o=1 for one cycle, result=0x00000020, ovf_o=0.
- 4 beats (ctl 01,00,00,10), neuron elements = 0x0002 and weight elements = 0xFFFF (-1), with vld_i=0 for 3 cycles between beats 2 and 3 -> result=0xFFFFFF00 (-256), a single vld_o 8 cycles after the last beat.
- SAT=1, a single beat with all elements 0x7FFF x 0x7FFF -> result=0x7FFFFFFF, ovf_o=1. Then all elements 0x8000 x 0x7FFF -> result=0x80000000, ovf_o=1.
- FRAC=8, SAT=0, all elements 0x0100 x 0x0100 in a single beat -> result=0x00002000, ovf_o=0.
- Back-to-back single-beat vectors with element values 1, 2 and 3 on consecutive cycles -> vld_o high for 3 consecutive cycles with results 0x20, 0x80, 0x120. Then a first beat issued mid-vector -> the earlier partial vector is discarded and only the new sum is reported.
- rst pulsed 3 cycles after the last beat of a vector -> no vld_o follows. All outputs read 0, and the next vector returns its correct result.
